// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment display path.
//   NIB_W    : width of one hex digit
//   GLYPH_W  : width of a logical abcdefg pattern
//   SEG_W    : width of the full segment bus {dp, a..g}
//   SEG_DP   : bit index of the decimal point within the segment bus
//   GLYPHS   : 16-entry logical (active-high) abcdefg table, bit 6 = a
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned SEG_DP  = 7;

    // Hex glyphs, logical abcdefg; b and d are the lowercase shapes.
    localparam logic [GLYPH_W-1:0] GLYPHS [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

endpackage : seg7_pkg

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to logical seven-segment pattern.
//   i_nib     : hex digit value 0..F
//   o_glyph_c : logical abcdefg pattern (1 = segment lit), bit 6 = a
// ---------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0]   i_nib,
    output logic [GLYPH_W-1:0] o_glyph_c
);

    // Table lookup; every nibble value has an entry so no default is needed.
    always_comb begin
        o_glyph_c = GLYPHS[i_nib];
    end

endmodule : seg7_decode

// File: rtl/display7seg_mux.sv
// ---------------------------------------------------------------------------
// display7seg_mux
// Time-multiplexed N-digit seven-segment driver with per-digit decimal point,
// double-buffered data, leading-zero blanking and selectable polarity.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   data_in    : hex nibbles, digit k = data_in[4k+3:4k], digit 0 rightmost
//   dp_in      : decimal point per digit
//   load       : capture data_in/dp_in into the shadow register
//   lzb_en     : leading-zero blanking enable
//   blank      : force every digit dark
//   seg        : {dp,a,b,c,d,e,f,g}, registered, physical polarity
//   an         : digit enables, one-hot when active, registered
//   frame_done : one-cycle pulse when the shadow is committed to the display
// ---------------------------------------------------------------------------
module display7seg_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NIB_W*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        load,
    input  logic                        lzb_en,
    input  logic                        blank,
    output logic [SEG_W-1:0]            seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int unsigned PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned LAST_IDX = NUM_DIGITS - 1;

    // Inactive levels for the physical pins.
    localparam logic [SEG_W-1:0]      SEG_OFF = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Elaboration-time parameter sanity.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
        $error("display7seg_mux: NUM_DIGITS must be 1..16");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("display7seg_mux: SCAN_DIV must be >= 2");
    end

    // Scan timing
    logic [PRE_W-1:0] r_pre;
    logic [IDX_W-1:0] r_idx;
    logic             w_tick;
    logic             w_commit;

    // Shadow (written by load) and display (committed at frame boundary)
    logic [NUM_DIGITS-1:0][NIB_W-1:0] r_shadow_data;
    logic [NUM_DIGITS-1:0]            r_shadow_dp;
    logic [NUM_DIGITS-1:0][NIB_W-1:0] r_disp_data;
    logic [NUM_DIGITS-1:0]            r_disp_dp;

    // Selected-digit datapath
    logic [NIB_W-1:0]      w_nib;
    logic                  w_dp_sel;
    logic [GLYPH_W-1:0]    w_glyph;
    logic [NUM_DIGITS-1:0] w_dark;
    logic                  w_lit;
    logic [SEG_W-1:0]      w_seg_log;
    logic [NUM_DIGITS-1:0] w_an_log;
    logic [SEG_W-1:0]      w_seg_phys;
    logic [NUM_DIGITS-1:0] w_an_phys;

    // Output registers
    logic [SEG_W-1:0]      r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    assign w_tick   = (r_pre == PRE_W'(SCAN_DIV - 1));
    // A frame ends on the tick that wraps the last digit back to digit 0.
    assign w_commit = w_tick && (r_idx == IDX_W'(LAST_IDX));

    // Prescaler, digit index and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_commit;
            if (w_tick) begin
                r_pre <= '0;
                if (r_idx == IDX_W'(LAST_IDX)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    // Shadow register: last load before a commit wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
        end else if (load) begin
            r_shadow_data <= data_in;
            r_shadow_dp   <= dp_in;
        end
    end

    // Display register: a load coinciding with the commit lands in the shadow
    // on the same edge, so it is picked up only at the following boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_data <= '0;
            r_disp_dp   <= '0;
        end else if (w_commit) begin
            r_disp_data <= r_shadow_data;
            r_disp_dp   <= r_shadow_dp;
        end
    end

    // Leading-zero blanking, walked from the most significant digit down so a
    // digit is dark only while every digit above it is dark as well.
    always_comb begin
        logic w_above_dark;
        w_dark       = '0;
        w_above_dark = 1'b1;
        for (int k = int'(LAST_IDX); k >= 1; k--) begin
            w_dark[k]    = w_above_dark && lzb_en &&
                           (r_disp_data[k] == NIB_W'(0)) && !r_disp_dp[k];
            w_above_dark = w_dark[k];
        end
    end

    assign w_nib    = r_disp_data[r_idx];
    assign w_dp_sel = r_disp_dp[r_idx];

    seg7_decode u_decode (
        .i_nib     (w_nib),
        .o_glyph_c (w_glyph)
    );

    // Logical (active-high) segment and anode values for the current slot.
    always_comb begin
        w_lit     = !blank && !w_dark[r_idx];
        w_seg_log = '0;
        w_an_log  = '0;
        if (w_lit) begin
            w_seg_log[SEG_DP]      = w_dp_sel;
            w_seg_log[SEG_DP-1:0]  = w_glyph;
            w_an_log               = NUM_DIGITS'(1) << r_idx;
        end
    end

    assign w_seg_phys = ACTIVE_LOW ? ~w_seg_log : w_seg_log;
    assign w_an_phys  = ACTIVE_LOW ? ~w_an_log  : w_an_log;

    // seg and an share one register stage so they always switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_seg_phys;
            r_an  <= w_an_phys;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule : display7seg_mux
